// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output stream FIFO: FSM state encoding and default sizes.
package fir_pkg;

  localparam int FIR_DATA_WIDTH = 32;
  localparam int FIR_DEPTH      = 16;

  typedef logic [1:0] fir_state_t;

  localparam fir_state_t IDLE  = 2'd0;
  localparam fir_state_t RUN   = 2'd1;
  localparam fir_state_t DRAIN = 2'd2;

endpackage

// File: rtl/fir_stream_fifo_if.sv
// AXI-stream style handshake bundle: upstream (ss_*) into the FIFO, downstream (sm_*) out of it.
interface fir_stream_fifo_if #(
  parameter int pDATA_WIDTH = 32
);

  logic                   ss_tvalid;
  logic [pDATA_WIDTH-1:0] ss_tdata;
  logic                   ss_tlast;
  logic                   ss_tready;

  logic                   sm_tvalid;
  logic [pDATA_WIDTH-1:0] sm_tdata;
  logic                   sm_tlast;
  logic                   sm_tready;

  // Environment side: drives the upstream beat and downstream ready.
  modport master (
    output ss_tvalid, ss_tdata, ss_tlast,
    input  ss_tready,
    input  sm_tvalid, sm_tdata, sm_tlast,
    output sm_tready
  );

  // FIFO side.
  modport slave (
    input  ss_tvalid, ss_tdata, ss_tlast,
    output ss_tready,
    output sm_tvalid, sm_tdata, sm_tlast,
    input  sm_tready
  );

endinterface

// File: rtl/fir_fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
module fir_fifo_mem #(
  parameter  int pWIDTH = 33,
  parameter  int pDEPTH = 16,
  localparam int AW     = $clog2(pDEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [pWIDTH-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [pWIDTH-1:0] rdata
);

  logic [pWIDTH-1:0] mem [pDEPTH];

  // NOTE: storage has no reset; occupancy is tracked by pointers, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fir_stream_fifo.sv
// First-word-fall-through stream FIFO with frame tracking (IDLE/RUN/DRAIN).
// Define FIR_STREAM_FIFO_STATS_EN to add beat_cnt and max_level statistics outputs.
module fir_stream_fifo
  import fir_pkg::*;
#(
  parameter  int pDATA_WIDTH = FIR_DATA_WIDTH,
  parameter  int pDEPTH      = FIR_DEPTH,
  localparam int AW          = $clog2(pDEPTH)
) (
  input  logic                    axis_clk,
  input  logic                    axis_rst,
  fir_stream_fifo_if.slave        axis,
  output logic [AW:0]             level,
  output logic                    frame_done
`ifdef FIR_STREAM_FIFO_STATS_EN
  ,
  output logic [31:0]             beat_cnt,
  output logic [AW:0]             max_level
`endif
);

  fir_state_t    state, state_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level_nxt;
  logic          push, pop;
  logic [pDATA_WIDTH:0] rd_entry;

  // Readiness looks only at registered state, so a pop on a full FIFO frees space for the next cycle only.
  assign axis.ss_tready = !axis_rst && (level != AW'(0) + (AW+1)'(pDEPTH) ? 1'b1 : 1'b0)
                          && (state != DRAIN);
  assign axis.sm_tvalid = (level != '0);
  assign push           = axis.ss_tvalid & axis.ss_tready;
  assign pop            = axis.sm_tvalid & axis.sm_tready;

  assign axis.sm_tdata  = rd_entry[pDATA_WIDTH-1:0];
  assign axis.sm_tlast  = rd_entry[pDATA_WIDTH];
  assign frame_done     = pop & axis.sm_tlast;

  fir_fifo_mem #(
    .pWIDTH (pDATA_WIDTH + 1),
    .pDEPTH (pDEPTH)
  ) u_mem (
    .clk   (axis_clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({axis.ss_tlast, axis.ss_tdata}),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (push) state_nxt = axis.ss_tlast ? DRAIN : RUN;
      RUN:     if (push && axis.ss_tlast) state_nxt = DRAIN;
      DRAIN:   if (frame_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      state  <= state_nxt;
      level  <= level_nxt;
      // Pointer width equals log2(depth), so increment wraps depth-1 -> 0.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef FIR_STREAM_FIFO_STATS_EN
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      beat_cnt  <= '0;
      max_level <= '0;
    end else begin
      if (pop && (beat_cnt != '1)) beat_cnt <= beat_cnt + 1'b1;
      if (level_nxt > max_level)   max_level <= level_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_fir_stream_fifo.sv
// Directed self-checking bench for fir_stream_fifo (stats checks active when FIR_STREAM_FIFO_STATS_EN is defined).
module tb_fir_stream_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int AW = $clog2(DEPTH);

  logic          axis_clk = 1'b0;
  logic          axis_rst;
  logic [AW:0]   level;
  logic          frame_done;
`ifdef FIR_STREAM_FIFO_STATS_EN
  logic [31:0]   beat_cnt;
  logic [AW:0]   max_level;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int fd_count = 0;
  int fd_base;

  fir_stream_fifo_if #(.pDATA_WIDTH(DW)) axis ();

  fir_stream_fifo #(
    .pDATA_WIDTH (DW),
    .pDEPTH      (DEPTH)
  ) dut (
    .axis_clk   (axis_clk),
    .axis_rst   (axis_rst),
    .axis       (axis),
    .level      (level),
    .frame_done (frame_done)
`ifdef FIR_STREAM_FIFO_STATS_EN
    ,
    .beat_cnt   (beat_cnt),
    .max_level  (max_level)
`endif
  );

  always #5 axis_clk = ~axis_clk;

  // frame_done pulses counted mid-cycle, away from the active edge.
  always @(negedge axis_clk) if (frame_done === 1'b1) fd_count++;

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic l);
    axis.ss_tvalid = v;
    axis.ss_tdata  = d;
    axis.ss_tlast  = l;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    axis_rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    axis.sm_tready = 1'b0;

    // ---------------- reset state ----------------
    tick(); tick();
    check("rst_level",      64'(level),          64'd0);
    check("rst_sm_tvalid",  64'(axis.sm_tvalid), 64'd0);
    check("rst_ss_tready",  64'(axis.ss_tready), 64'd0);
    check("rst_frame_done", 64'(frame_done),     64'd0);
    axis_rst = 1'b0;
    #1;
    check("rel_ss_tready",  64'(axis.ss_tready), 64'd1);

    // ---------------- 5-beat frame, sm_tready=1 ----------------
    axis.sm_tready = 1'b1;
    drive(1'b1, 32'd1, 1'b0);
    #1;
    check("no_bypass", 64'(axis.sm_tvalid), 64'd0);
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, DW'(i), (i == 5));
      tick();
      check("f5_valid", 64'(axis.sm_tvalid), 64'd1);
      check("f5_data",  64'(axis.sm_tdata),  64'(i));
      check("f5_level", 64'(level),          64'd1);
    end
    drive(1'b0, '0, 1'b0);
    #1;
    check("f5_last",       64'(axis.sm_tlast),  64'd1);
    check("f5_frame_done", 64'(frame_done),     64'd1);
    check("f5_drain_rdy",  64'(axis.ss_tready), 64'd0);
    tick();
    check("f5_empty",      64'(level),          64'd0);
    check("f5_fd_low",     64'(frame_done),     64'd0);
    check("f5_idle_rdy",   64'(axis.ss_tready), 64'd1);
    check("f5_fd_count",   64'(fd_count),       64'd1);

    // ---------------- fill 16 with sm_tready=0 ----------------
    axis.sm_tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, DW'(100 + i), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    #1;
    check("full_level", 64'(level),          64'd16);
    check("full_rdy",   64'(axis.ss_tready), 64'd0);
    check("full_head",  64'(axis.sm_tdata),  64'd100);
    tick();
    check("full_stable", 64'(axis.sm_tdata), 64'd100);

    // ---------------- full: push+pop attempted together ----------------
    drive(1'b1, 32'd200, 1'b0);
    axis.sm_tready = 1'b1;
    #1;
    check("fp_rdy_blocked", 64'(axis.ss_tready), 64'd0);
    tick();
    check("fp_level15", 64'(level),          64'd15);
    check("fp_rdy_back", 64'(axis.ss_tready), 64'd1);
    check("fp_head101", 64'(axis.sm_tdata),  64'd101);
    tick();
    drive(1'b0, '0, 1'b0);
    check("fp_level_pp", 64'(level), 64'd15);
    // Queue now holds 102..115 then 200; pointers have wrapped past depth-1.
    for (int k = 0; k < 15; k++) begin
      check("fp_drain_data", 64'(axis.sm_tdata), (k < 14) ? 64'(102 + k) : 64'd200);
      tick();
    end
    check("fp_empty_level", 64'(level),          64'd0);
    check("fp_empty_valid", 64'(axis.sm_tvalid), 64'd0);

    // ---------------- tlast behind 3 queued beats ----------------
    axis.sm_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, DW'(31 + i), (i == 3));
      tick();
    end
    drive(1'b1, 32'd99, 1'b0);
    fd_base = fd_count;
    #1;
    check("tl_level4", 64'(level),          64'd4);
    check("tl_rdy0",   64'(axis.ss_tready), 64'd0);
    axis.sm_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("tl_pop_data", 64'(axis.sm_tdata),  64'(31 + i));
      check("tl_pop_fd",   64'(frame_done),     64'd0);
      check("tl_pop_rdy",  64'(axis.ss_tready), 64'd0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    #1;
    check("tl_last_data", 64'(axis.sm_tdata), 64'd34);
    check("tl_last_fd",   64'(frame_done),    64'd1);
    tick();
    check("tl_level0",   64'(level),              64'd0);
    check("tl_rdy1",     64'(axis.ss_tready),     64'd1);
    check("tl_fd_once",  64'(fd_count - fd_base), 64'd1);

    // ---------------- reset with 7 beats queued ----------------
    axis.sm_tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, DW'(50 + i), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    check("mr_level7", 64'(level), 64'd7);
    axis_rst = 1'b1;
    tick();
    check("mr_level0", 64'(level),          64'd0);
    check("mr_valid0", 64'(axis.sm_tvalid), 64'd0);
    check("mr_rdy0",   64'(axis.ss_tready), 64'd0);
    axis_rst = 1'b0;
    #1;
    check("mr_rdy1", 64'(axis.ss_tready), 64'd1);
    drive(1'b1, 32'd77, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    check("mr_new_data",  64'(axis.sm_tdata), 64'd77);
    check("mr_new_level", 64'(level),         64'd1);
    axis.sm_tready = 1'b1;
    tick();
    check("mr_new_empty", 64'(level), 64'd0);

`ifdef FIR_STREAM_FIFO_STATS_EN
    // ---------------- statistics ----------------
    axis_rst = 1'b1;
    axis.sm_tready = 1'b0;
    tick();
    axis_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      axis.sm_tready = (i >= 6);
      drive(1'b1, DW'(i), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    axis.sm_tready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("st_level0",    64'(level),     64'd0);
    check("st_beat_cnt",  64'(beat_cnt),  64'd10);
    check("st_max_level", 64'(max_level), 64'd6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
